// File: rtl/lcd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_cmd_arbiter
//
// Purpose:
//   Owns the single HD44780 lcd_controller. After reset it plays the fixed
//   init sequence 0x38, 0x0C, 0x01, 0x06 (rs=0). It then serves NREQ command
//   sources round-robin, one command at a time. A settle delay of DLY_CYCLES
//   follows every completed command.
//
// Ports:
//   iclk, irst_n    clock, asynchronous active-low reset
//   ireq[NREQ]      level request per source, held until its oack
//   idata[NREQ*8]   byte per source, source k on [8k+7:8k]
//   irs[NREQ]       register select per source (0=command, 1=data)
//   oack[NREQ]      one-cycle pulse: that source's command done incl. settle
//   obusy           high whenever the FSM is not in IDLE
//   oinit_done      sticky once the init sequence has completed
//   ocmd_data/rs    command byte / register select to lcd_controller
//   ocmd_start      start strobe to lcd_controller, held until icmd_done
//   icmd_done       completion pulse from lcd_controller
//   odbg_state      current FSM state, for checkers and debug
//
// Handshakes:
//   Source side: ireq[k] is a level. The byte and rs are captured on the grant
//   cycle; later changes are ignored. oack[k] pulses for one cycle once the
//   command and its settle delay are finished, and the source drops ireq[k]
//   the following cycle. Dropping ireq early never aborts a granted command.
//   Controller side: ocmd_start rises with stable ocmd_data/ocmd_rs and stays
//   high, with data held, until icmd_done is seen. icmd_done arriving while
//   no command is outstanding is ignored.
// ---------------------------------------------------------------------------
module lcd_cmd_arbiter #(
  parameter int NREQ       = 2,
  parameter int DLY_CYCLES = 262143
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic [NREQ-1:0]   ireq,
  input  logic [NREQ*8-1:0] idata,
  input  logic [NREQ-1:0]   irs,
  output logic [NREQ-1:0]   oack,
  output logic              obusy,
  output logic              oinit_done,
  output logic [7:0]        ocmd_data,
  output logic              ocmd_rs,
  output logic              ocmd_start,
  input  logic              icmd_done,
  output logic [2:0]        odbg_state
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = $clog2(DLY_CYCLES + 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(DLY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT_ISSUE = 3'd0,
    S_INIT_WAIT  = 3'd1,
    S_INIT_DLY   = 3'd2,
    S_IDLE       = 3'd3,
    S_WAIT       = 3'd4,
    S_DLY        = 3'd5,
    S_ACK        = 3'd6
  } state_t;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    init_byte = 8'h0C;  // display on, cursor off
      2'd2:    init_byte = 8'h01;  // clear display
      default: init_byte = 8'h06;  // entry mode: increment, no shift
    endcase
  endfunction

  // State and datapath registers
  state_t          r_state;
  logic [1:0]      r_idx;
  logic [DW-1:0]   r_dly;
  logic [7:0]      r_data;
  logic            r_rs;
  logic            r_start;
  logic [NREQ-1:0] r_ack;
  logic            r_init_done;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_last_grant;

  // Next-state values
  state_t          w_state_nxt;
  logic [1:0]      w_idx_nxt;
  logic [DW-1:0]   w_dly_nxt;
  logic [7:0]      w_data_nxt;
  logic            w_rs_nxt;
  logic            w_start_nxt;
  logic [NREQ-1:0] w_ack_nxt;
  logic            w_init_done_nxt;
  logic [GW-1:0]   w_grant_nxt;
  logic [GW-1:0]   w_last_nxt;

  // Round-robin search
  logic            w_found;
  logic [GW-1:0]   w_grant;
  logic [GW:0]     w_sum;
  logic [GW-1:0]   w_cand;

  // Candidates are visited in order last_grant+1, +2, ... (mod NREQ), so the
  // source served last always has the lowest priority next time. The sum is
  // one bit wider than an index so last_grant+NREQ cannot overflow.
  always_comb begin
    w_found = 1'b0;
    w_grant = r_last_grant;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_sum = {1'b0, r_last_grant} + (GW+1)'(i);
      if (w_sum >= (GW+1)'(NREQ)) w_sum = w_sum - (GW+1)'(NREQ);
      w_cand = w_sum[GW-1:0];
      if (!w_found && ireq[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_dly_nxt       = r_dly;
    w_data_nxt      = r_data;
    w_rs_nxt        = r_rs;
    w_start_nxt     = r_start;
    w_ack_nxt       = '0;
    w_init_done_nxt = r_init_done;
    w_grant_nxt     = r_grant;
    w_last_nxt      = r_last_grant;

    case (r_state)
      S_INIT_ISSUE: begin
        w_data_nxt  = init_byte(r_idx);
        w_rs_nxt    = 1'b0;
        w_start_nxt = 1'b1;
        w_state_nxt = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (icmd_done) begin
          w_start_nxt = 1'b0;
          w_state_nxt = S_INIT_DLY;
        end
      end
      S_INIT_DLY: begin
        if (r_dly == DLY_LAST) begin
          w_dly_nxt = '0;
          if (r_idx == 2'd3) begin
            w_init_done_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = S_INIT_ISSUE;
          end
        end else begin
          w_dly_nxt = r_dly + DW'(1);
        end
      end
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_grant;
          w_data_nxt  = idata[{w_grant, 3'b000} +: 8];
          w_rs_nxt    = irs[w_grant];
          w_start_nxt = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (icmd_done) begin
          w_start_nxt = 1'b0;
          w_state_nxt = S_DLY;
        end
      end
      S_DLY: begin
        if (r_dly == DLY_LAST) begin
          w_dly_nxt          = '0;
          // oack is registered so it is high exactly while the FSM sits in ACK
          w_ack_nxt[r_grant] = 1'b1;
          w_state_nxt        = S_ACK;
        end else begin
          w_dly_nxt = r_dly + DW'(1);
        end
      end
      S_ACK: begin
        w_last_nxt  = r_grant;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_INIT_ISSUE;
      end
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state      <= S_INIT_ISSUE;
      r_idx        <= '0;
      r_dly        <= '0;
      r_data       <= '0;
      r_rs         <= 1'b0;
      r_start      <= 1'b0;
      r_ack        <= '0;
      r_init_done  <= 1'b0;
      r_grant      <= '0;
      r_last_grant <= GW'(NREQ - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_dly        <= w_dly_nxt;
      r_data       <= w_data_nxt;
      r_rs         <= w_rs_nxt;
      r_start      <= w_start_nxt;
      r_ack        <= w_ack_nxt;
      r_init_done  <= w_init_done_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  assign oack       = r_ack;
  assign oinit_done = r_init_done;
  assign ocmd_data  = r_data;
  assign ocmd_rs    = r_rs;
  assign ocmd_start = r_start;
  assign odbg_state = r_state;
  // The reset state is INIT_ISSUE, not IDLE, so busy is masked while reset is
  // held to keep every output low during reset.
  assign obusy      = irst_n & (r_state != S_IDLE);

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
module tb_lcd_cmd_arbiter;

  localparam int NREQ = 2;
  localparam int DLY  = 4;

  logic        iclk   = 1'b0;
  logic        irst_n = 1'b0;
  logic [1:0]  ireq   = '0;
  logic [15:0] idata  = '0;
  logic [1:0]  irs    = '0;
  logic [1:0]  oack;
  logic        obusy;
  logic        oinit_done;
  logic [7:0]  ocmd_data;
  logic        ocmd_rs;
  logic        ocmd_start;
  logic        icmd_done;
  logic [2:0]  odbg_state;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic rs1_early = 1'b0;
  logic [7:0] exp_q[$];

  lcd_cmd_arbiter #(.NREQ(NREQ), .DLY_CYCLES(DLY)) dut (
    .iclk       (iclk),
    .irst_n     (irst_n),
    .ireq       (ireq),
    .idata      (idata),
    .irs        (irs),
    .oack       (oack),
    .obusy      (obusy),
    .oinit_done (oinit_done),
    .ocmd_data  (ocmd_data),
    .ocmd_rs    (ocmd_rs),
    .ocmd_start (ocmd_start),
    .icmd_done  (icmd_done),
    .odbg_state (odbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  // lcd_controller model: odone pulses 3 cycles after istart is first seen
  logic       m_busy;
  logic [1:0] m_cnt;
  always @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      m_busy    <= 1'b0;
      m_cnt     <= '0;
      icmd_done <= 1'b0;
    end else begin
      icmd_done <= 1'b0;
      if (!m_busy) begin
        if (ocmd_start) begin
          m_busy <= 1'b1;
          m_cnt  <= 2'd1;
        end
      end else if (m_cnt == 2'd2) begin
        icmd_done <= 1'b1;
        m_cnt     <= 2'd3;
      end else if (m_cnt == 2'd3) begin
        m_busy <= 1'b0;
        m_cnt  <= '0;
      end else begin
        m_cnt <= m_cnt + 2'd1;
      end
    end
  end

  // Flags any user data write (rs=1) issued before init has completed
  always @(negedge iclk) begin
    if (irst_n && ocmd_start && ocmd_rs && !oinit_done) rs1_early = 1'b1;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // sel: 0=ocmd_start, 1=icmd_done, 2=any oack, 3=oinit_done
  task automatic wait_for(input int sel, input string name, output int c);
    logic hit;
    c = cyc;
    for (int n = 0; n < 200; n++) begin
      @(negedge iclk);
      case (sel)
        0:       hit = ocmd_start;
        1:       hit = icmd_done;
        2:       hit = |oack;
        default: hit = oinit_done;
      endcase
      if (hit) begin
        c = cyc;
        return;
      end
    end
    n_chk++;
    n_err++;
    $display("FAIL %s: got no event within 200 cycles, expected one", name);
    c = cyc;
  endtask

  // Checks the four init commands, their spacing and the init-done timing.
  task automatic run_init(input string tag);
    int c_start;
    int c_done;
    int c_prev;
    logic [7:0] e;
    exp_q = {8'h38, 8'h0C, 8'h01, 8'h06};
    c_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_for(0, {tag, "_start"}, c_start);
      e = exp_q.pop_front();
      chk({tag, "_data"}, {24'h0, ocmd_data}, {24'h0, e});
      chk({tag, "_rs"}, {31'h0, ocmd_rs}, 32'h0);
      chk({tag, "_no_ack"}, {30'h0, oack}, 32'h0);
      chk({tag, "_not_done_yet"}, {31'h0, oinit_done}, 32'h0);
      // done at d, settle d+1..d+4, issue d+5, start seen d+6
      if (k > 0) chk({tag, "_gap"}, c_start - c_prev, 6);
      wait_for(1, {tag, "_odone"}, c_done);
      c_prev = c_done;
    end
    wait_for(3, {tag, "_init_done"}, c_start);
    chk({tag, "_init_done_lat"}, c_start - c_prev, 5);
    chk({tag, "_idle_after_init"}, {31'h0, obusy}, 32'h0);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [15:0] data;
    logic [1:0]  rs;
    logic [7:0]  exp_data;
    logic        exp_rs;
    logic [1:0]  exp_ack;
  } vec_t;

  // Caller is at a negedge with the FSM in IDLE.
  task automatic run_vec(input vec_t v, input string name);
    int c0;
    int cs;
    int cd;
    int ca;
    ireq  = v.req;
    idata = v.data;
    irs   = v.rs;
    c0 = cyc;
    wait_for(0, {name, "_start"}, cs);
    chk({name, "_grant_lat"}, cs - c0, 1);
    chk({name, "_data"}, {24'h0, ocmd_data}, {24'h0, v.exp_data});
    chk({name, "_rs"}, {31'h0, ocmd_rs}, {31'h0, v.exp_rs});
    wait_for(1, {name, "_odone"}, cd);
    wait_for(2, {name, "_ack"}, ca);
    chk({name, "_ack_val"}, {30'h0, oack}, {30'h0, v.exp_ack});
    chk({name, "_ack_lat"}, ca - cd, 5);
    ireq = '0;
    @(negedge iclk);
    chk({name, "_ack_pulse"}, {30'h0, oack}, 32'h0);
    chk({name, "_idle"}, {31'h0, obusy}, 32'h0);
  endtask

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cs;
    int cd;
    int ca;
    int c_prev;
    logic any_start;

    //        req    data      rs     exp_data exp_rs exp_ack
    vecs[0] = '{2'b01, 16'h0041, 2'b01, 8'h41, 1'b1, 2'b01};
    vecs[1] = '{2'b10, 16'h4200, 2'b00, 8'h42, 1'b0, 2'b10};
    vecs[2] = '{2'b11, 16'hB1A0, 2'b10, 8'hA0, 1'b0, 2'b01};
    vecs[3] = '{2'b11, 16'hB1A0, 2'b10, 8'hB1, 1'b1, 2'b10};
    vecs[4] = '{2'b10, 16'hC300, 2'b10, 8'hC3, 1'b1, 2'b10};
    vecs[5] = '{2'b10, 16'h0700, 2'b00, 8'h07, 1'b0, 2'b10};
    vecs[6] = '{2'b01, 16'h00FF, 2'b11, 8'hFF, 1'b1, 2'b01};

    // Reset state
    repeat (3) @(negedge iclk);
    chk("rst_oack", {30'h0, oack}, 32'h0);
    chk("rst_obusy", {31'h0, obusy}, 32'h0);
    chk("rst_init_done", {31'h0, oinit_done}, 32'h0);
    chk("rst_start", {31'h0, ocmd_start}, 32'h0);
    chk("rst_data", {24'h0, ocmd_data}, 32'h0);
    irst_n = 1'b1;

    // Init sequence with no requests
    run_init("init1");

    // Single and contended requests
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        any_start = 1'b0;
        repeat (4) begin
          @(negedge iclk);
          any_start = any_start | ocmd_start;
        end
        chk("vec0_no_second_cmd", {31'h0, any_start}, 32'h0);
      end
    end

    // Request dropped and data changed mid-service
    ireq  = 2'b01;
    idata = 16'h0041;
    irs   = 2'b00;
    wait_for(0, "drop_start", cs);
    ireq  = 2'b00;
    idata = 16'h0055;
    wait_for(1, "drop_odone", cd);
    chk("drop_data_held", {24'h0, ocmd_data}, 32'h41);
    wait_for(2, "drop_ack", ca);
    chk("drop_ack_val", {30'h0, oack}, 32'h1);
    @(negedge iclk);

    // Reset during settle of a user command
    ireq  = 2'b10;
    idata = 16'h7700;
    irs   = 2'b10;
    wait_for(0, "rst_mid_start", cs);
    wait_for(1, "rst_mid_odone", cd);
    repeat (2) @(negedge iclk);
    irst_n = 1'b0;
    ireq   = 2'b11;
    idata  = 16'h4241;
    irs    = 2'b11;
    #1;
    chk("rst_mid_obusy", {31'h0, obusy}, 32'h0);
    chk("rst_mid_start0", {31'h0, ocmd_start}, 32'h0);
    chk("rst_mid_data", {24'h0, ocmd_data}, 32'h0);
    chk("rst_mid_rs", {31'h0, ocmd_rs}, 32'h0);
    chk("rst_mid_oack", {30'h0, oack}, 32'h0);
    chk("rst_mid_init_done", {31'h0, oinit_done}, 32'h0);
    repeat (2) @(negedge iclk);
    irst_n = 1'b1;

    // Init repeats from 0x38 while both sources request
    run_init("init2");
    chk("no_rs1_before_init", {31'h0, rs1_early}, 32'h0);

    // Both requests held: alternation starting with source 0
    c_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_for(0, $sformatf("alt%0d_start", k), cs);
      chk($sformatf("alt%0d_data", k), {24'h0, ocmd_data},
          (k % 2 == 0) ? 32'h41 : 32'h42);
      chk($sformatf("alt%0d_rs", k), {31'h0, ocmd_rs}, 32'h1);
      if (k > 0) chk($sformatf("alt%0d_regrant_lat", k), cs - c_prev, 2);
      wait_for(1, $sformatf("alt%0d_odone", k), cd);
      wait_for(2, $sformatf("alt%0d_ack", k), ca);
      chk($sformatf("alt%0d_ack_val", k), {30'h0, oack},
          (k % 2 == 0) ? 32'h1 : 32'h2);
      c_prev = ca;
    end
    ireq = '0;
    @(negedge iclk);
    chk("alt_ack_pulse", {30'h0, oack}, 32'h0);
    repeat (3) @(negedge iclk);
    chk("alt_idle_end", {31'h0, obusy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
